// File: rtl/gpu_pkg.sv
// GPU shared definitions: VGA timing, framebuffer geometry,
// pixel field layout and scanout swap states.
package gpu_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int SCALE     = 4;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int PIX_R_HI = 15;
  localparam int PIX_R_LO = 11;
  localparam int PIX_G_HI = 10;
  localparam int PIX_G_LO = 6;
  localparam int PIX_B_HI = 5;
  localparam int PIX_B_LO = 1;
  localparam int PIX_T    = 0;

  typedef enum logic {
    SW_IDLE    = 1'b0,
    SW_PENDING = 1'b1
  } swap_state_t;

  typedef struct packed {
    logic de;
    logic hs_n;
    logic vs_n;
  } sync_t;

endpackage

// File: rtl/video_timing.sv
// Raster counters with sync, active and vblank generation.
// Shared by scanout and the vsync interrupt logic.
module video_timing
  import gpu_pkg::*;
#(
  parameter int HA  = H_ACTIVE,
  parameter int HFP = H_FP,
  parameter int HSW = H_SYNC,
  parameter int HBP = H_BP,
  parameter int VA  = V_ACTIVE,
  parameter int VFP = V_FP,
  parameter int VSW = V_SYNC,
  parameter int VBP = V_BP,
  parameter int HW  = $clog2(HA + HFP + HSW + HBP),
  parameter int VW  = $clog2(VA + VFP + VSW + VBP)
) (
  input  logic          clk,
  input  logic          rstn,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          vblank,
  output logic          vblank_start
);

  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(HA);
  localparam logic [HW-1:0] HS_BEG = HW'(HA + HFP);
  localparam logic [HW-1:0] HS_END = HW'(HA + HFP + HSW);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(VA);
  localparam logic [VW-1:0] VS_BEG = VW'(VA + VFP);
  localparam logic [VW-1:0] VS_END = VW'(VA + VFP + VSW);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign h_cnt   = r_h;
  assign v_cnt   = r_v;
  assign active  = (r_h < H_ACT) && (r_v < V_ACT);
  assign hsync_n = !((r_h >= HS_BEG) && (r_h < HS_END));
  assign vsync_n = !((r_v >= VS_BEG) && (r_v < VS_END));
  assign vblank  = (r_v >= V_ACT);

  assign vblank_start = (r_h == '0) && (r_v == V_ACT);

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: read mapping, 2-stage video pipeline
// and double-buffer swap applied at vblank start.
module fb_scanout
  import gpu_pkg::*;
#(
  parameter int SC  = SCALE,
  parameter int HA  = H_ACTIVE,
  parameter int HFP = H_FP,
  parameter int HSW = H_SYNC,
  parameter int HBP = H_BP,
  parameter int VA  = V_ACTIVE,
  parameter int VFP = V_FP,
  parameter int VSW = V_SYNC,
  parameter int VBP = V_BP
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [7:0]  rd_x,
  output logic [7:0]  rd_y,
  output logic        rd_en,
  output logic        rd_buf,
  input  logic [15:0] rd_data,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        vid_de,
  output logic [4:0]  vid_r,
  output logic [4:0]  vid_g,
  output logic [4:0]  vid_b,
  output logic        vblank
);

  localparam int HW = $clog2(HA + HFP + HSW + HBP);
  localparam int VW = $clog2(VA + VFP + VSW + VBP);
  localparam int SH = $clog2(SC);

  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic          w_act;
  logic          w_hs_n;
  logic          w_vs_n;
  logic          w_vbs;
  logic          w_unused_t;

  video_timing #(
    .HA (HA),  .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VA (VA),  .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .HW (HW),  .VW (VW)
  ) u_timing (
    .clk         (clk),
    .rstn        (rstn),
    .h_cnt       (w_h),
    .v_cnt       (w_v),
    .active      (w_act),
    .hsync_n     (w_hs_n),
    .vsync_n     (w_vs_n),
    .vblank      (vblank),
    .vblank_start(w_vbs)
  );

  // Held in reset the counters sit at (0,0), which is active.
  assign rd_en = rstn & w_act;
  assign rd_x  = rd_en ? 8'(w_h >> SH) : 8'd0;
  assign rd_y  = rd_en ? 8'(w_v >> SH) : 8'd0;

  assign w_unused_t = rd_data[PIX_T];

  sync_t      r_s1;
  logic       r_de;
  logic       r_hs_n;
  logic       r_vs_n;
  logic [4:0] r_r;
  logic [4:0] r_g;
  logic [4:0] r_b;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1 <= '{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1};
    end else begin
      r_s1 <= '{de: w_act, hs_n: w_hs_n, vs_n: w_vs_n};
    end
  end

  // rd_data arrives alongside stage 1, so colour joins here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_de   <= 1'b0;
      r_hs_n <= 1'b1;
      r_vs_n <= 1'b1;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
    end else begin
      r_de   <= r_s1.de;
      r_hs_n <= r_s1.hs_n;
      r_vs_n <= r_s1.vs_n;
      r_r    <= r_s1.de ? rd_data[PIX_R_HI:PIX_R_LO] : '0;
      r_g    <= r_s1.de ? rd_data[PIX_G_HI:PIX_G_LO] : '0;
      r_b    <= r_s1.de ? rd_data[PIX_B_HI:PIX_B_LO] : '0;
    end
  end

  assign vid_de    = r_de;
  assign vid_hsync = r_hs_n;
  assign vid_vsync = r_vs_n;
  assign vid_r     = r_r;
  assign vid_g     = r_g;
  assign vid_b     = r_b;

  swap_state_t r_state;
  swap_state_t w_state_nx;
  logic        w_ack;
  logic        r_buf;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= SW_IDLE;
      r_buf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_buf   <= r_buf ^ w_ack;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ack      = 1'b0;
    unique case (r_state)
      SW_IDLE: begin
        if (swap_req) w_state_nx = SW_PENDING;
      end
      SW_PENDING: begin
        if (w_vbs) begin
          w_state_nx = SW_IDLE;
          w_ack      = 1'b1;
        end
      end
    endcase
  end

  assign swap_ack = rstn & w_ack;
  assign rd_buf   = r_buf;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: reduced-timing instance against a
// raster model, plus a full-VGA instance for early lines.
module tb_fb_scanout;

  localparam int SS = 2;
  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } vid_t;

  localparam vid_t VID_RST = '{1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic swap_req = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  s_rd_x, s_rd_y;
  logic        s_rd_en, s_rd_buf, s_ack;
  logic [15:0] s_rd_data = 16'h0;
  logic        s_hs, s_vs, s_de, s_vb;
  logic [4:0]  s_r, s_g, s_b;

  logic [7:0]  d_rd_x, d_rd_y;
  logic        d_rd_en, d_rd_buf, d_ack;
  logic [15:0] d_rd_data = 16'h0;
  logic        d_hs, d_vs, d_de, d_vb;
  logic [4:0]  d_r, d_g, d_b;

  int checks = 0;
  int errors = 0;
  int unsigned salt;

  fb_scanout #(
    .SC(SS), .HA(HA), .HFP(HF), .HSW(HS), .HBP(HB),
    .VA(VA), .VFP(VF), .VSW(VS), .VBP(VB)
  ) u_small (
    .clk(clk), .rstn(rstn),
    .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_en(s_rd_en),
    .rd_buf(s_rd_buf), .rd_data(s_rd_data),
    .swap_req(swap_req), .swap_ack(s_ack),
    .vid_hsync(s_hs), .vid_vsync(s_vs), .vid_de(s_de),
    .vid_r(s_r), .vid_g(s_g), .vid_b(s_b),
    .vblank(s_vb)
  );

  fb_scanout u_vga (
    .clk(clk), .rstn(rstn),
    .rd_x(d_rd_x), .rd_y(d_rd_y), .rd_en(d_rd_en),
    .rd_buf(d_rd_buf), .rd_data(d_rd_data),
    .swap_req(1'b0), .swap_ack(d_ack),
    .vid_hsync(d_hs), .vid_vsync(d_vs), .vid_de(d_de),
    .vid_r(d_r), .vid_g(d_g), .vid_b(d_b),
    .vblank(d_vb)
  );

  function automatic logic [15:0] pix(
    input bit b, input int x, input int y);
    int unsigned k;
    if (!b && x == 0 && y == 0) return 16'hF83F;
    if (!b && x == 1 && y == 0) return 16'hFFFE;
    k = x * 40503 + y * 2719 + int'(b) * 977;
    return 16'(k ^ salt);
  endfunction

  // Framebuffer memories: data one cycle after the strobe.
  always @(posedge clk) begin
    s_rd_data <= s_rd_en ?
      pix(s_rd_buf, int'(s_rd_x), int'(s_rd_y)) :
      16'($urandom);
    d_rd_data <= d_rd_en ?
      pix(d_rd_buf, int'(d_rd_x), int'(d_rd_y)) :
      16'($urandom);
  end

  function automatic vid_t model_vid(
    input int h, input int v, input bit b);
    vid_t t;
    logic [15:0] p;
    t.de = (h < HA) && (v < VA);
    t.hs = !(h >= HA + HF && h < HA + HF + HS);
    t.vs = !(v >= VA + VF && v < VA + VF + VS);
    p = pix(b, h / SS, v / SS);
    t.r = t.de ? p[15:11] : 5'd0;
    t.g = t.de ? p[10:6] : 5'd0;
    t.b = t.de ? p[5:1] : 5'd0;
    return t;
  endfunction

  int   mh = 0;
  int   mv = 0;
  bit   mpend = 1'b0;
  bit   mbuf = 1'b0;
  vid_t e1 = VID_RST;
  vid_t e2 = VID_RST;

  // Raster model for the small instance.
  always @(posedge clk) begin
    if (!rstn) begin
      mh <= 0;
      mv <= 0;
      mpend <= 1'b0;
      mbuf <= 1'b0;
      e1 <= VID_RST;
      e2 <= VID_RST;
    end else begin
      e1 <= model_vid(mh, mv, mbuf);
      e2 <= e1;
      if (mpend && mh == 0 && mv == VA) begin
        mbuf <= ~mbuf;
        mpend <= 1'b0;
      end else if (!mpend && swap_req) begin
        mpend <= 1'b1;
      end
      if (mh == HT - 1) begin
        mh <= 0;
        mv <= (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  task automatic wait_at(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FT && !ok; i++) begin
      @(negedge clk);
      if (mh == h && mv == v) ok = 1'b1;
    end
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic test_reset();
    swap_req = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_hs, s_vs, s_de, s_rd_buf, s_ack, s_rd_en} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 110000",
        {s_hs, s_vs, s_de, s_rd_buf, s_ack, s_rd_en});
    end
    checks++;
    if ({s_r, s_g, s_b, s_rd_x, s_rd_y} !== 31'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
        {s_r, s_g, s_b, s_rd_x, s_rd_y});
    end
    checks++;
    if ({d_hs, d_vs, d_de, d_rd_buf, d_rd_en} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_vga got %b want 11000",
        {d_hs, d_vs, d_de, d_rd_buf, d_rd_en});
    end
    rstn = 1'b1;
    #1;
    checks++;
    if ({s_rd_en, s_rd_x, s_rd_y} !== 17'h10000) begin
      errors++;
      $display("FAIL release_rd got %h want 10000",
        {s_rd_en, s_rd_x, s_rd_y});
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (s_de !== (k >= 2) || d_de !== (k >= 2)) begin
        errors++;
        $display("FAIL first_de clk%0d got %b/%b want %b",
          k, s_de, d_de, k >= 2);
      end
      if (k == 2) begin
        checks++;
        if ({s_r, s_g, s_b} !== {5'd31, 5'd0, 5'd31}) begin
          errors++;
          $display("FAIL colour_f83f got %0d/%0d/%0d want 31/0/31",
            s_r, s_g, s_b);
        end
      end
      if (k == 4) begin
        checks++;
        if ({s_r, s_g, s_b} !== {5'd31, 5'd31, 5'd31}) begin
          errors++;
          $display("FAIL colour_fffe got %0d/%0d/%0d want 31/31/31",
            s_r, s_g, s_b);
        end
      end
    end
  endtask

  task automatic test_default_timing();
    int h, v, hp, hs_low;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    hs_low = 0;
    for (int n = 0; n < 5 * 800; n++) begin
      h = n % 800;
      v = n / 800;
      checks++;
      if (d_rd_en !== (h < 640)) begin
        errors++;
        $display("FAIL vga_rd_en h%0d v%0d got %b", h, v, d_rd_en);
      end
      checks++;
      if (d_rd_x !== 8'(h < 640 ? h / 4 : 0) ||
          d_rd_y !== 8'(h < 640 ? v / 4 : 0)) begin
        errors++;
        $display("FAIL vga_rd_xy h%0d v%0d got %0d,%0d",
          h, v, d_rd_x, d_rd_y);
      end
      checks++;
      if (d_vb !== 1'b0) begin
        errors++;
        $display("FAIL vga_vblank v%0d got %b want 0", v, d_vb);
      end
      if (n >= 2) begin
        hp = (n - 2) % 800;
        checks++;
        if (d_hs !== !(hp >= 656 && hp < 752) ||
            d_de !== (hp < 640)) begin
          errors++;
          $display("FAIL vga_hs_de h%0d got %b/%b", hp, d_hs, d_de);
        end
        if (!d_hs) hs_low++;
      end
      @(negedge clk);
    end
    checks++;
    if (hs_low !== 5 * 96) begin
      errors++;
      $display("FAIL vga_hs_width got %0d want %0d", hs_low, 5 * 96);
    end
  endtask

  task automatic test_frames(input int nfr, input int pct);
    int de_cnt, vs_low;
    bit exp_ack;
    de_cnt = 0;
    vs_low = 0;
    for (int c = 0; c < nfr * FT; c++) begin
      exp_ack = mpend && mh == 0 && mv == VA;
      checks++;
      if ({s_de, s_hs, s_vs, s_r, s_g, s_b} !== e2) begin
        errors++;
        $display("FAIL vid h%0d v%0d got %h want %h", mh, mv,
          {s_de, s_hs, s_vs, s_r, s_g, s_b}, e2);
      end
      checks++;
      if (s_rd_en !== (mh < HA && mv < VA) ||
          s_rd_x !== 8'(s_rd_en ? mh / SS : 0) ||
          s_rd_y !== 8'(s_rd_en ? mv / SS : 0)) begin
        errors++;
        $display("FAIL rd h%0d v%0d got %b %0d %0d", mh, mv,
          s_rd_en, s_rd_x, s_rd_y);
      end
      checks++;
      if (s_rd_buf !== mbuf || s_ack !== exp_ack) begin
        errors++;
        $display("FAIL swap h%0d v%0d got %b/%b want %b/%b", mh, mv,
          s_rd_buf, s_ack, mbuf, exp_ack);
      end
      checks++;
      if (s_vb !== (mv >= VA)) begin
        errors++;
        $display("FAIL vblank v%0d got %b", mv, s_vb);
      end
      if (s_de) de_cnt++;
      if (!s_vs) vs_low++;
      swap_req = ($urandom_range(0, 99) < pct);
      @(negedge clk);
    end
    swap_req = 1'b0;
    checks++;
    if (de_cnt !== nfr * HA * VA || vs_low !== nfr * VS * HT) begin
      errors++;
      $display("FAIL frame_counts got de%0d vs%0d want de%0d vs%0d",
        de_cnt, vs_low, nfr * HA * VA, nfr * VS * HT);
    end
  endtask

  task automatic test_swap();
    bit ok;
    int c, acks;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_at(0, 3, ok);
    pulse_swap();
    c = 1;
    while (!s_ack && c < 2 * FT) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c !== (VA - 3) * HT || s_rd_buf !== 1'b0) begin
      errors++;
      $display("FAIL swap_single got c%0d buf%b want c%0d buf0",
        c, s_rd_buf, (VA - 3) * HT);
    end
    @(negedge clk);
    checks++;
    if (s_rd_buf !== 1'b1 || s_ack !== 1'b0) begin
      errors++;
      $display("FAIL swap_toggle got buf%b ack%b want 1/0",
        s_rd_buf, s_ack);
    end
    wait_at(0, 3, ok);
    pulse_swap();
    wait_at(0, 8, ok);
    pulse_swap();
    acks = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      if (s_ack) acks++;
      @(negedge clk);
    end
    checks++;
    if (acks !== 1 || s_rd_buf !== 1'b0) begin
      errors++;
      $display("FAIL swap_double got acks%0d buf%b want 1/0",
        acks, s_rd_buf);
    end
    wait_at(0, VA, ok);
    checks++;
    if (!ok || s_ack !== 1'b0) begin
      errors++;
      $display("FAIL vbs_idle got ok%b ack%b want 1/0", ok, s_ack);
    end
    pulse_swap();
    c = 1;
    while (!s_ack && c < 2 * FT) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c !== FT) begin
      errors++;
      $display("FAIL swap_at_vbs got c%0d want %0d", c, FT);
    end
    @(negedge clk);
    checks++;
    if (s_rd_buf !== 1'b1) begin
      errors++;
      $display("FAIL swap_at_vbs_buf got %b want 1", s_rd_buf);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int acks, vb_at;
    wait_at(0, 2, ok);
    pulse_swap();
    wait_at(0, 8, ok);
    rstn = 1'b0;
    #1;
    checks++;
    if (s_ack !== 1'b0 || s_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_comb got ack%b en%b want 0/0",
        s_ack, s_rd_en);
    end
    @(negedge clk);
    checks++;
    if ({s_de, s_hs, s_vs, s_r, s_g, s_b} !== VID_RST ||
        s_rd_buf !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_out got %h buf%b want %h buf0",
        {s_de, s_hs, s_vs, s_r, s_g, s_b}, s_rd_buf, VID_RST);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if ({s_rd_en, s_rd_x, s_rd_y} !== 17'h10000) begin
      errors++;
      $display("FAIL mid_rst_restart got %h want 10000",
        {s_rd_en, s_rd_x, s_rd_y});
    end
    acks = 0;
    vb_at = -1;
    for (int i = 0; i < FT + HT; i++) begin
      if (s_ack) acks++;
      if (s_vb && vb_at < 0) vb_at = i;
      @(negedge clk);
    end
    checks++;
    if (acks !== 0 || vb_at !== VA * HT) begin
      errors++;
      $display("FAIL mid_rst_frame got acks%0d vb%0d want 0/%0d",
        acks, vb_at, VA * HT);
    end
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_default_timing();
    test_frames(8, 3);
    test_swap();
    test_reset_midframe();
    test_frames(4, 10);
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
